mem_responder: RTL and testbench

- Backing-store responder for the cache's memory-side port. The cache acts as the initiator and issues enable, rw, addr and data; this block stalls for a configurable number of wait states, performs the access, and acknowledges with a level handshake.
- Replaces the zero-latency RAM model so that cache miss sequencing can be exercised against real memory latency.
- Exposes word monitors 0..7 for bench and board observation.

---
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: wait-state backing store for the cache memory-side port.
// Accepts a level request in IDLE, stalls wait_cycles edges in WAIT, performs the access,
// then holds ready in RESP until the initiator drops enab (four-phase handshake).
// Optional feature macro: MEM_POSTED_WRITE_EN (writes commit and respond on the accepting edge).
module mem_responder #(
   parameter int unsigned d_width     = 8,
   parameter int unsigned a_width     = 8,
   parameter int unsigned depth       = 8,
   parameter int unsigned wait_cycles = 3
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               enab,
   input  logic               rw,
   input  logic [a_width-1:0] addr,
   input  logic [d_width-1:0] data_in,
   output logic [d_width-1:0] data_out,
   output logic               ready,
   output logic               busy,
   output logic               err,
   output logic [d_width-1:0] mem0,
   output logic [d_width-1:0] mem1,
   output logic [d_width-1:0] mem2,
   output logic [d_width-1:0] mem3,
   output logic [d_width-1:0] mem4,
   output logic [d_width-1:0] mem5,
   output logic [d_width-1:0] mem6,
   output logic [d_width-1:0] mem7
);

   localparam int unsigned IdxW     = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [3:0]  WaitLoad = 4'(wait_cycles);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t               r_state;
   logic [3:0]           r_cnt;
   logic                 r_rw;
   logic [a_width-1:0]   r_addr;
   logic [d_width-1:0]   r_data;
   logic [d_width-1:0]   r_dout;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_err;
   logic [d_width-1:0]   r_mem [depth];

   logic                 w_tgt_oor;
   logic [IdxW-1:0]      w_tgt_idx;

   // Range check and word index for the latched target
   assign w_tgt_oor = (32'(r_addr) >= depth);
   assign w_tgt_idx = r_addr[IdxW-1:0];

`ifdef MEM_POSTED_WRITE_EN
   logic                 w_req_oor;
   logic [IdxW-1:0]      w_req_idx;

   // Posted writes decode the live request rather than the latched target
   assign w_req_oor = (32'(addr) >= depth);
   assign w_req_idx = addr[IdxW-1:0];
`endif

   // Handshake FSM, wait counter, storage and registered response outputs
   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_dout  <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_mem   <= '{default: '0};
      end else begin
         unique case (r_state)
            StIdle: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               if (enab) begin
                  // Inputs are captured here; later changes cannot affect this access
                  r_rw    <= rw;
                  r_addr  <= addr;
                  r_data  <= data_in;
                  r_cnt   <= WaitLoad;
                  r_busy  <= 1'b1;
                  r_state <= StWait;
`ifdef MEM_POSTED_WRITE_EN
                  if (rw) begin
                     r_ready <= 1'b1;
                     r_state <= StResp;
                     if (w_req_oor) begin
                        r_err  <= 1'b1;
                        r_dout <= '0;
                     end else begin
                        r_mem[w_req_idx] <= data_in;
                     end
                  end
`endif
               end
            end
            StWait: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  // Access completes regardless of enab; an early drop still commits
                  r_ready <= 1'b1;
                  r_state <= StResp;
                  if (w_tgt_oor) begin
                     r_err  <= 1'b1;
                     r_dout <= '0;
                  end else if (r_rw) begin
                     r_mem[w_tgt_idx] <= r_data;
                  end else begin
                     r_dout <= r_mem[w_tgt_idx];
                  end
               end
            end
            StResp: begin
               // data_out deliberately keeps its value after retirement
               if (!enab) begin
                  r_state <= StIdle;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign data_out = r_dout;
   assign ready    = r_ready;
   assign busy     = r_busy;
   assign err      = r_err;

   assign mem0 = r_mem[0];
   assign mem1 = r_mem[1];
   assign mem2 = r_mem[2];
   assign mem3 = r_mem[3];
   assign mem4 = r_mem[4];
   assign mem5 = r_mem[5];
   assign mem6 = r_mem[6];
   assign mem7 = r_mem[7];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a default instance (wait_cycles=3) and a wait_cycles=0 instance
// share the same request inputs; each response is checked against a word-array model.
module tb_mem_responder;

   localparam int WcA   = 3;
   localparam int WcB   = 0;
   localparam int Depth = 8;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       enab = 1'b0;
   logic       rw = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] data_in = 8'h00;

   logic [7:0] dout_a, dout_b;
   logic       ready_a, busy_a, err_a, ready_b, busy_b, err_b;
   logic [7:0] mon_a [8];
   logic [7:0] mon_b [8];

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model [8];
   logic [7:0] last_dout;

   always #5 clk = ~clk;

   mem_responder u_a (
      .clk(clk), .clr(clr), .enab(enab), .rw(rw), .addr(addr), .data_in(data_in),
      .data_out(dout_a), .ready(ready_a), .busy(busy_a), .err(err_a),
      .mem0(mon_a[0]), .mem1(mon_a[1]), .mem2(mon_a[2]), .mem3(mon_a[3]),
      .mem4(mon_a[4]), .mem5(mon_a[5]), .mem6(mon_a[6]), .mem7(mon_a[7])
   );

   mem_responder #(.wait_cycles(WcB)) u_b (
      .clk(clk), .clr(clr), .enab(enab), .rw(rw), .addr(addr), .data_in(data_in),
      .data_out(dout_b), .ready(ready_b), .busy(busy_b), .err(err_b),
      .mem0(mon_b[0]), .mem1(mon_b[1]), .mem2(mon_b[2]), .mem3(mon_b[3]),
      .mem4(mon_b[4]), .mem5(mon_b[5]), .mem6(mon_b[6]), .mem7(mon_b[7])
   );

   typedef struct {
      bit         w;
      logic [7:0] a;
      logic [7:0] d;
      bit         early;
      bit         exp_err;
      logic [7:0] exp_dout;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mons(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk({tag, " mon_a"}, 32'(mon_a[i]), 32'(model[i]));
         chk({tag, " mon_b"}, 32'(mon_b[i]), 32'(model[i]));
      end
   endtask

   task automatic do_reset(input int edges);
      clr  = 1'b0;
      enab = 1'b0;
      for (int i = 0; i < edges; i++) tick();
      clr = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      last_dout = 8'h00;
   endtask

   // One full four-phase transaction; expected response supplied by the caller
   task automatic txn(input bit w, input logic [7:0] a, input logic [7:0] d, input int hold,
                      input bit early, input bit exp_err, input logic [7:0] exp_dout);
      int lat_a = WcA + 1;
      int lat_b = WcB + 1;
      int got_a = -1;
      int got_b = -1;
      logic [7:0] da = 8'h00, db = 8'h00;
      logic ea = 1'b0, eb = 1'b0;
`ifdef MEM_POSTED_WRITE_EN
      if (w) begin
         lat_a = 0;
         lat_b = 0;
      end
`endif
      if (w && (int'(a) < Depth)) model[a[2:0]] = d;
      enab = 1'b1; rw = w; addr = a; data_in = d;
      tick();
      chk("busy_after_accept", 32'(busy_a), 32'd1);
      // Scramble request fields; the latched values must win
      rw = 1'($urandom); addr = 8'($urandom); data_in = 8'($urandom);
      if (early) enab = 1'b0;
      for (int n = 0; n <= 20; n++) begin
         if (ready_a && got_a < 0) begin got_a = n; da = dout_a; ea = err_a; end
         if (ready_b && got_b < 0) begin got_b = n; db = dout_b; eb = err_b; end
         if (got_a >= 0 && got_b >= 0) break;
         tick();
      end
      chk("latency_a", 32'(got_a), 32'(lat_a));
      chk("latency_b", 32'(got_b), 32'(lat_b));
      chk("err_a", 32'(ea), 32'(exp_err));
      chk("err_b", 32'(eb), 32'(exp_err));
      chk("dout_a", 32'(da), 32'(exp_dout));
      chk("dout_b", 32'(db), 32'(exp_dout));
      check_mons("txn");
      if (early) begin
         tick();
         chk("early_ready_a_drop", 32'(ready_a), 32'd0);
         chk("early_busy_a_drop", 32'(busy_a), 32'd0);
         chk("early_busy_b", 32'(busy_b), 32'd0);
      end else begin
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_ready_a", 32'(ready_a), 32'd1);
            chk("hold_dout_a", 32'(dout_a), 32'(exp_dout));
            chk("hold_err_b", 32'(err_b), 32'(exp_err));
         end
         enab = 1'b0;
         tick();
         chk("retire_ready_a", 32'(ready_a), 32'd0);
         chk("retire_busy_a", 32'(busy_a), 32'd0);
         chk("retire_err_a", 32'(err_a), 32'd0);
         chk("retire_ready_b", 32'(ready_b), 32'd0);
         chk("retire_dout_a", 32'(dout_a), 32'(exp_dout));
      end
      check_mons("after");
      last_dout = exp_dout;
   endtask

   vec_t vecs [9];

   initial begin
      vecs[0] = '{w: 1, a: 8'h05, d: 8'hA7, early: 0, exp_err: 0, exp_dout: 8'h00};
      vecs[1] = '{w: 0, a: 8'h05, d: 8'h00, early: 0, exp_err: 0, exp_dout: 8'hA7};
      vecs[2] = '{w: 0, a: 8'h20, d: 8'h00, early: 0, exp_err: 1, exp_dout: 8'h00};
      vecs[3] = '{w: 1, a: 8'h20, d: 8'h3C, early: 0, exp_err: 1, exp_dout: 8'h00};
      vecs[4] = '{w: 1, a: 8'h02, d: 8'h11, early: 1, exp_err: 0, exp_dout: 8'h00};
      vecs[5] = '{w: 0, a: 8'h02, d: 8'h00, early: 0, exp_err: 0, exp_dout: 8'h11};
      vecs[6] = '{w: 1, a: 8'h07, d: 8'h5A, early: 0, exp_err: 0, exp_dout: 8'h11};
      vecs[7] = '{w: 0, a: 8'h00, d: 8'h00, early: 0, exp_err: 0, exp_dout: 8'h00};
      vecs[8] = '{w: 0, a: 8'h07, d: 8'h00, early: 0, exp_err: 0, exp_dout: 8'h5A};

      do_reset(2);
      // Preload every monitored word, then reset must clear them all
      for (int i = 0; i < 8; i++) txn(1'b1, 8'(i), 8'hFF, 0, 1'b0, 1'b0, 8'h00);
      do_reset(2);
      check_mons("reset");
      chk("reset_ready", 32'(ready_a), 32'd0);
      chk("reset_busy", 32'(busy_a), 32'd0);
      chk("reset_err", 32'(err_a), 32'd0);
      chk("reset_dout", 32'(dout_a), 32'd0);

      for (int i = 0; i < 9; i++)
         txn(vecs[i].w, vecs[i].a, vecs[i].d, 1, vecs[i].early, vecs[i].exp_err,
             vecs[i].exp_dout);

      // Reset mid-access: write abandoned, no response, next request works
      enab = 1'b1; rw = 1'b1; addr = 8'h03; data_in = 8'h55;
      tick();
      tick();
      clr = 1'b0;
      tick();
      clr  = 1'b1;
      enab = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      last_dout = 8'h00;
      chk("midreset_mem3", 32'(mon_a[3]), 32'd0);
      chk("midreset_busy", 32'(busy_a), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midreset_no_ready", 32'(ready_a), 32'd0);
      end
      check_mons("midreset");
      txn(1'b1, 8'h03, 8'h55, 0, 1'b0, 1'b0, 8'h00);
      txn(1'b1, 8'h01, 8'h9C, 0, 1'b0, 1'b0, 8'h00);
      txn(1'b0, 8'h01, 8'h00, 0, 1'b0, 1'b0, 8'h9C);

      // Randomized transactions against the word-array model
      for (int k = 0; k < 60; k++) begin
         bit         w = 1'($urandom);
         logic [7:0] a = 8'($urandom_range(0, 11));
         logic [7:0] d = 8'($urandom);
         bit         e = ($urandom_range(0, 4) == 0);
         bit         oor = (int'(a) >= Depth);
         logic [7:0] exp = oor ? 8'h00 : (w ? last_dout : model[a[2:0]]);
         txn(w, a, d, int'($urandom_range(0, 2)), e, oor, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
